// File: rtl/host_stream_loader.sv
// Host stream command decoder: parses header/address/data packets from a
// valid/ready word stream into registered TPU memory writes and start pulses.
module host_stream_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  mem_wr_en,
    output logic                  mem_wr_sel,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  tpu_start,
    input  logic                  tpu_busy,
    output logic                  busy,
    output logic                  err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, START_WAIT} state_t;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_WR_W  = 4'd1;
    localparam logic [3:0] OP_WR_I  = 4'd2;
    localparam logic [3:0] OP_START = 4'd3;

    state_t                state_q, state_d;
    logic                  rdy_q;
    logic                  sel_q, sel_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            rem_q, rem_d;
    logic                  err_q, err_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  start_q, start_d;
    logic                  accept;
    logic [3:0]            opcode;

    // rdy_q keeps s_ready low during reset and for the first edge after it.
    assign s_ready     = rdy_q && (state_q != START_WAIT);
    assign accept      = s_valid && s_ready;
    assign opcode      = s_data[15:12];
    assign mem_wr_en   = wr_en_q;
    assign mem_wr_sel  = sel_q;
    assign mem_wr_addr = wr_addr_q;
    assign mem_wr_data = wr_data_q;
    assign tpu_start   = start_q;
    assign busy        = (state_q != IDLE);
    assign err         = err_q;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        err_d     = err_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        start_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (opcode)
                        OP_NOP: err_d = 1'b0;
                        OP_WR_W, OP_WR_I: begin
                            sel_d   = (opcode == OP_WR_I);
                            rem_d   = s_data[7:0];
                            state_d = ADDR;
                        end
                        OP_START: state_d = START_WAIT;
                        default:  err_d = 1'b1;
                    endcase
                end
            end
            ADDR: begin
                if (accept) begin
                    addr_d  = s_data[ADDR_WIDTH-1:0];
                    state_d = (rem_q == 8'd0) ? IDLE : DATA;
                end
            end
            DATA: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = s_data;
                    addr_d    = addr_q + ADDR_WIDTH'(1);
                    rem_d     = rem_q - 8'd1;
                    if (rem_q == 8'd1) state_d = IDLE;
                end
            end
            START_WAIT: begin
                if (!tpu_busy) begin
                    start_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            rdy_q     <= 1'b0;
            sel_q     <= 1'b0;
            addr_q    <= '0;
            rem_q     <= '0;
            err_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rdy_q     <= 1'b1;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            start_q   <= start_d;
        end
    end

endmodule

// File: tb/tb_host_stream_loader.sv
// Scoreboard bench for host_stream_loader: directed packets push expected
// writes; a negedge monitor pops and compares every mem_wr_en cycle.
module tb_host_stream_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_ready;
    logic        mem_wr_en;
    logic        mem_wr_sel;
    logic [7:0]  mem_wr_addr;
    logic [15:0] mem_wr_data;
    logic        tpu_start;
    logic        tpu_busy;
    logic        busy;
    logic        err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int wr_cnt   = 0;
    int start_cnt = 0;
    logic [24:0] exp_q[$];
    int          wr_cyc[$];

    host_stream_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
        .clk(clk), .reset(rst_n), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .mem_wr_en(mem_wr_en), .mem_wr_sel(mem_wr_sel),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .tpu_start(tpu_start), .tpu_busy(tpu_busy), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (tpu_start) start_cnt++;
        if (mem_wr_en) begin
            logic [24:0] e;
            wr_cnt++;
            wr_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got sel=%0d addr=0x%0h data=0x%0h, none expected",
                         mem_wr_sel, mem_wr_addr, mem_wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({mem_wr_sel, mem_wr_addr, mem_wr_data} !== e) begin
                    failures++;
                    $display("FAIL write: got sel=%0d addr=0x%0h data=0x%0h expected sel=%0d addr=0x%0h data=0x%0h",
                             mem_wr_sel, mem_wr_addr, mem_wr_data, e[24], e[23:16], e[15:0]);
                end
            end
        end
    end

    task automatic expect_wr(input logic sel, input logic [7:0] a, input logic [15:0] d);
        exp_q.push_back({sel, a, d});
    endtask

    // Offer one word; returns #1 after the edge that transferred it.
    task automatic send(input logic [15:0] w);
        bit ok;
        int n;
        s_valid = 1'b1;
        s_data  = w;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: word 0x%0h not accepted, required accept within 50 cycles", w);
        end
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int w0, s0;
        rst_n = 1'b0; s_valid = 1'b1; s_data = 16'h1003; tpu_busy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", s_ready, 0);
        check("rst_outputs", {mem_wr_en, tpu_start, busy, err, mem_wr_sel}, 0);
        check("rst_addr_data", {mem_wr_addr, mem_wr_data}, 0);
        @(posedge clk); #1;
        s_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_rst", s_ready, 1);
        @(posedge clk); #1;

        // Weight load, back-to-back.
        expect_wr(1'b0, 8'h10, 16'hAAAA);
        expect_wr(1'b0, 8'h11, 16'hBBBB);
        expect_wr(1'b0, 8'h12, 16'hCCCC);
        send(16'h1003); send(16'h0010);
        send(16'hAAAA); send(16'hBBBB); send(16'hCCCC);
        @(negedge clk);
        check("wl_busy_done", busy, 0);
        idle(2);
        check("wl_count", wr_cnt, 3);
        check("wl_back_to_back", wr_cyc[2] - wr_cyc[0], 2);

        // Input load with address wrap and a mid-packet stall.
        expect_wr(1'b1, 8'hFF, 16'h1111);
        expect_wr(1'b1, 8'h00, 16'h2222);
        send(16'h2002); send(16'h00FF); send(16'h1111);
        w0 = wr_cnt;
        idle(3);
        @(negedge clk);
        check("stall_no_write", wr_cnt - w0, 1);
        check("stall_busy", busy, 1);
        @(posedge clk); #1;
        send(16'h2222);
        idle(2);
        check("wrap_count", wr_cnt, 5);

        // Start gated by tpu_busy.
        tpu_busy = 1'b1;
        s0 = start_cnt;
        send(16'h3000);
        idle(4);
        @(negedge clk);
        check("start_wait_ready", s_ready, 0);
        check("start_wait_busy", busy, 1);
        check("start_gated", start_cnt - s0, 0);
        @(posedge clk); #1;
        tpu_busy = 1'b0;
        idle(4);
        @(negedge clk);
        check("start_one_pulse", start_cnt - s0, 1);
        check("start_ready_back", s_ready, 1);
        @(posedge clk); #1;

        // Undefined opcode, zero length, NOP clear.
        w0 = wr_cnt;
        send(16'h7000);
        @(negedge clk);
        check("err_set", err, 1);
        check("err_idle", busy, 0);
        @(posedge clk); #1;
        send(16'h1000); send(16'h0005);
        idle(3);
        @(negedge clk);
        check("zero_len_idle", busy, 0);
        check("zero_len_no_wr", wr_cnt - w0, 0);
        check("err_sticky", err, 1);
        @(posedge clk); #1;
        send(16'h0000);
        @(negedge clk);
        check("err_clear", err, 0);
        @(posedge clk); #1;

        // Reset mid-packet, then a fresh packet.
        expect_wr(1'b0, 8'h40, 16'hDEAD);
        send(16'h1004); send(16'h0040); send(16'hDEAD);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        w0 = wr_cnt;
        s_valid = 1'b1; s_data = 16'hBEEF;
        idle(2);
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_wr_en", mem_wr_en, 0);
        @(posedge clk); #1;
        s_valid = 1'b0;
        rst_n = 1'b1;
        idle(3);
        check("midrst_no_wr", wr_cnt - w0, 0);
        expect_wr(1'b0, 8'h20, 16'h1234);
        send(16'h1001); send(16'h0020); send(16'h1234);
        idle(3);
        check("post_rst_count", wr_cnt - w0, 1);
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
